// File: rtl/morphle_edge_seq.sv
`default_nettype none
// ============================================================================
//  Module   : morphle_edge_seq
//  Purpose  : Drives one edge column of ycfsm cells through their
//             return-to-empty handshake from a valid/ready request.
//  Revision : 1.0  initial release
// ============================================================================
module morphle_edge_seq #(
    parameter int WIDTH      = 8,
    parameter int SYNC       = 2,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 255,
    parameter int RST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_in,
    input  logic [WIDTH-1:0]   req_match,
    input  logic [WIDTH-1:0]   req_en,
    output logic               arr_reset,
    output logic [2*WIDTH-1:0] arr_in,
    output logic [2*WIDTH-1:0] arr_match,
    input  logic [2*WIDTH-1:0] arr_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [1:0]         rsp_err,
    output logic               busy
);

    // Last cycle index of each timed phase; SETTLE is expected to be >= 1.
    localparam logic [7:0] c_OUT_LAST = 8'(SYNC + SETTLE - 1);
    localparam logic [7:0] c_ME_LAST  = 8'(SETTLE - 1);
    localparam logic [7:0] c_TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_RST_LAST = 8'(RST_CYCLES - 1);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_V0    = 2'd1;
    localparam logic [1:0] c_V1    = 2'd2;
    localparam logic [1:0] c_ILL   = 2'd3;

    localparam logic [1:0] c_ERR_OK  = 2'd0;
    localparam logic [1:0] c_ERR_TO  = 2'd1;
    localparam logic [1:0] c_ERR_ILL = 2'd2;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_IDLE     = 4'd1,
        S_WAIT_OUT = 4'd2,
        S_REL_M    = 4'd3,
        S_WAIT_ME  = 4'd4,
        S_REL_I    = 4'd5,
        S_WAIT_IE  = 4'd6,
        S_RESP     = 4'd7
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   en_q, en_d;
    logic               pend_q, pend_d;
    logic [2*WIDTH-1:0] sync_q [SYNC];

    logic               arr_reset_q, arr_reset_d;
    logic [2*WIDTH-1:0] arr_in_q, arr_in_d;
    logic [2*WIDTH-1:0] arr_match_q, arr_match_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   w_lane_ok, w_lane_empty, w_lane_ill, w_lane_v1;
    logic [2*WIDTH-1:0] w_in_enc, w_match_enc;
    logic               w_fail;
    logic [1:0]         w_fail_code;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int s = 0; s < SYNC; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= arr_out;
            for (int s = 1; s < SYNC; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-lane decode: disabled lanes always look "done" and never illegal.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [1:0] w_code;
        assign w_code          = sync_q[SYNC-1][2*i +: 2];
        assign w_lane_ok[i]    = !en_q[i] || (w_code == c_V0) || (w_code == c_V1);
        assign w_lane_empty[i] = !en_q[i] || (w_code == c_EMPTY);
        assign w_lane_ill[i]   = en_q[i] && (w_code == c_ILL);
        assign w_lane_v1[i]    = en_q[i] && (w_code == c_V1);
        assign w_in_enc[2*i +: 2]    = !req_en[i] ? c_EMPTY : (req_in[i]    ? c_V1 : c_V0);
        assign w_match_enc[2*i +: 2] = !req_en[i] ? c_EMPTY : (req_match[i] ? c_V1 : c_V0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        en_d        = en_q;
        pend_d      = pend_q;
        arr_in_d    = arr_in_q;
        arr_match_d = arr_match_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        w_fail      = 1'b0;
        w_fail_code = c_ERR_OK;

        case (state_q)
            S_RST: begin
                if (cnt_q >= c_RST_LAST) begin
                    cnt_d = 8'd0;
                    if (pend_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        pend_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    en_d       = req_en;
                    rsp_data_d = '0;
                    rsp_err_d  = c_ERR_OK;
                    cnt_d      = 8'd0;
                    if (req_en == '0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d     = S_WAIT_OUT;
                        arr_in_d    = w_in_enc;
                        arr_match_d = w_match_enc;
                    end
                end
            end
            S_WAIT_OUT: begin
                if (|w_lane_ill) begin
                    w_fail      = 1'b1;
                    w_fail_code = c_ERR_ILL;
                end else if (cnt_q >= c_OUT_LAST && &w_lane_ok) begin
                    rsp_data_d  = w_lane_v1;
                    arr_match_d = '0;
                    state_d     = S_REL_M;
                end else if (cnt_q == c_TO_LAST) begin
                    w_fail      = 1'b1;
                    w_fail_code = c_ERR_TO;
                end
            end
            S_REL_M: begin
                state_d = S_WAIT_ME;
                cnt_d   = 8'd0;
            end
            S_WAIT_ME: begin
                if (cnt_q >= c_ME_LAST) begin
                    arr_in_d = '0;
                    state_d  = S_REL_I;
                end
            end
            S_REL_I: begin
                state_d = S_WAIT_IE;
                cnt_d   = 8'd0;
            end
            S_WAIT_IE: begin
                if (cnt_q >= c_OUT_LAST && &w_lane_empty) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end else if (cnt_q == c_TO_LAST) begin
                    w_fail      = 1'b1;
                    w_fail_code = c_ERR_TO;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = 8'd0;
            end
        endcase

        // Errors pulse the array reset before the response is offered.
        if (w_fail) begin
            state_d     = S_RST;
            cnt_d       = 8'd0;
            arr_in_d    = '0;
            arr_match_d = '0;
            rsp_data_d  = '0;
            rsp_err_d   = w_fail_code;
            pend_d      = 1'b1;
        end

        arr_reset_d = (state_d == S_RST);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_RST;
            cnt_q       <= 8'd0;
            en_q        <= '0;
            pend_q      <= 1'b0;
            arr_reset_q <= 1'b1;
            arr_in_q    <= '0;
            arr_match_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= c_ERR_OK;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            arr_reset_q <= arr_reset_d;
            arr_in_q    <= arr_in_d;
            arr_match_q <= arr_match_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign arr_reset = arr_reset_q;
    assign arr_in    = arr_in_q;
    assign arr_match = arr_match_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_morphle_edge_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morphle_edge_seq
//  Purpose  : Scoreboard bench for morphle_edge_seq with ycfsm lane models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morphle_edge_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_in = '0, req_match = '0, req_en = '0;
    logic             arr_reset;
    logic [15:0]      arr_in, arr_match, arr_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_err;
    logic             busy;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q [$];

    logic [15:0] model_out = '0;
    logic [7:0]  stuck = '0, force3 = '0;
    logic [15:0] prev_in = '0, prev_match = '0;
    logic [9:0]  mon_e;
    logic [1:0]  m_ci, m_cm, m_mo;
    logic        mask_mode = 1'b0;
    int          mask_viol = 0, rst_hi = 0, rv_cnt = 0;

    always #5 clk = ~clk;

    morphle_edge_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in(req_in), .req_match(req_match), .req_en(req_en),
        .arr_reset(arr_reset), .arr_in(arr_in), .arr_match(arr_match), .arr_out(arr_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ycfsm lane: out = in AND match once both are valid; empties when both empty.
    always @(negedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            m_ci = arr_in[2*i +: 2];
            m_cm = arr_match[2*i +: 2];
            m_mo = model_out[2*i +: 2];
            if (arr_reset)
                model_out[2*i +: 2] <= 2'd0;
            else if (m_mo == 2'd0 && !stuck[i] && (m_ci == 2'd1 || m_ci == 2'd2)
                     && (m_cm == 2'd1 || m_cm == 2'd2))
                model_out[2*i +: 2] <= (m_ci == 2'd2 && m_cm == 2'd2) ? 2'd2 : 2'd1;
            else if (m_mo != 2'd0 && m_ci == 2'd0 && m_cm == 2'd0)
                model_out[2*i +: 2] <= 2'd0;
        end
    end

    always_comb begin
        arr_out = model_out;
        for (int i = 0; i < WIDTH; i++)
            if (force3[i]) arr_out[2*i +: 2] = 2'b11;
    end

    // Monitor: scoreboard pops on handshake, plus protocol observers.
    always @(negedge clk) begin
        if (nreset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got data 0x%0h err %0d, required no response",
                         rsp_data, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(mon_e[9:2]));
                check("rsp_err", 32'(rsp_err), 32'(mon_e[1:0]));
                if (mon_e[1:0] == 2'd0)
                    check("model_empty_at_rsp", 32'(model_out), 32'd0);
            end
        end
        if (nreset && !arr_reset && prev_in != 16'd0 && arr_in == 16'd0)
            check("match_before_in", 32'(prev_match), 32'd0);
        if (mask_mode && arr_in[15:8] != 8'd0) mask_viol++;
        if (nreset && arr_reset) rst_hi++;
        if (rsp_valid) rv_cnt++;
        prev_in    = arr_in;
        prev_match = arr_match;
    end

    task automatic send(input logic [7:0] vin, input logic [7:0] vm, input logic [7:0] ven);
        int n;
        @(posedge clk); #1;
        req_in = vin; req_match = vm; req_en = ven; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait_bound", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int viol;

        // Reset values while nreset is held low, then the reset pulse length.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arr_reset", 32'(arr_reset), 32'd1);
        check("rst_arr_in", 32'(arr_in), 32'd0);
        check("rst_arr_match", 32'(arr_match), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data_err", {22'd0, rsp_data, rsp_err}, 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!arr_reset) break;
            n++;
        end
        check("rst_pulse_len", 32'(n), 32'd4);
        check("ready_cycle5", 32'(req_ready), 32'd1);

        // AND truth table across lanes.
        exp_q.push_back({8'hC0, 2'd0});
        send(8'hF0, 8'hCC, 8'hFF);
        drain();

        // Lane mask: upper lanes never driven.
        mask_viol = 0;
        mask_mode = 1'b1;
        exp_q.push_back({8'h0F, 2'd0});
        send(8'hFF, 8'hFF, 8'h0F);
        drain();
        mask_mode = 1'b0;
        check("mask_upper_idle", 32'(mask_viol), 32'd0);

        // No lanes enabled: immediate ok response.
        exp_q.push_back({8'h00, 2'd0});
        send(8'hFF, 8'hFF, 8'h00);
        drain();

        // Timeout with lane 3 silent, then recovery.
        stuck = 8'h08;
        rst_hi = 0;
        exp_q.push_back({8'h00, 2'd1});
        send(8'hFF, 8'hFF, 8'hFF);
        drain();
        check("timeout_rst_pulse", 32'(rst_hi), 32'd4);
        stuck = 8'h00;
        exp_q.push_back({8'hA5, 2'd0});
        send(8'hA5, 8'hFF, 8'hFF);
        drain();

        // Illegal code on lane 5.
        force3 = 8'h20;
        rst_hi = 0;
        exp_q.push_back({8'h00, 2'd2});
        send(8'hFF, 8'hFF, 8'hFF);
        drain();
        check("illegal_rst_pulse", 32'(rst_hi), 32'd4);
        check("illegal_arr_in_clr", 32'(arr_in), 32'd0);
        check("illegal_arr_match_clr", 32'(arr_match), 32'd0);

        // Same illegal lane, but disabled: ignored.
        exp_q.push_back({8'hDF, 2'd0});
        send(8'hFF, 8'hFF, 8'hDF);
        drain();
        force3 = 8'h00;

        // Backpressure: response held stable.
        rsp_ready = 1'b0;
        exp_q.push_back({8'h0C, 2'd0});
        send(8'h0F, 8'h3C, 8'hFF);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 8'h0C || rsp_err !== 2'd0) viol++;
        end
        check("bp_stable", 32'(viol), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        // Asynchronous reset in WAIT_ME: response lost.
        send(8'hF0, 8'hCC, 8'hFF);
        n = 0;
        while (!(arr_match == 16'd0 && arr_in != 16'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_me", 32'(arr_in != 16'd0), 32'd1);
        @(negedge clk);
        #1 nreset = 1'b0;
        #1;
        check("async_arr_in", 32'(arr_in), 32'd0);
        check("async_arr_reset", 32'(arr_reset), 32'd1);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        rv_cnt = 0;
        repeat (40) @(negedge clk);
        check("no_rsp_after_rst", 32'(rv_cnt), 32'd0);

        // Normal operation after the reset.
        exp_q.push_back({8'hC0, 2'd0});
        send(8'hF0, 8'hCC, 8'hFF);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
